// File: rtl/mux2x1_rr_arbiter.sv
// Round-robin 2:1 valid/ready arbiter with a single registered output slot.
// Define MUX2X1_ARB_FIXED_PRIO_EN for fixed priority (i0 always wins contention).
module mux2x1_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0_data,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1_data,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             select
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             select_q,    select_d;
    logic             can_load;
    logic             pick;
    logic             xfer;

`ifdef MUX2X1_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = i0_valid ? 1'b0 : 1'b1;
    end
`else
    logic last_q, last_d;

    // With both or neither requesting, the channel that did not win last goes next.
    always_comb begin
        pick = ~last_q;
        if (i0_valid && !i1_valid)
            pick = 1'b0;
        else if (i1_valid && !i0_valid)
            pick = 1'b1;
    end

    always_comb begin
        last_d = last_q;
        if (xfer)
            last_d = pick;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end
`endif

    // Reset holds both readys low so no beat is accepted and then discarded.
    always_comb begin
        can_load = !rst && (!out_valid_q || out_ready);
        i0_ready = can_load && (pick == 1'b0);
        i1_ready = can_load && (pick == 1'b1);
        xfer     = can_load && (i0_valid || i1_valid);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        select_d    = select_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = pick ? i1_data : i0_data;
            select_d    = pick;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            select_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            select_q    <= select_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign select    = select_q;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Directed bench for mux2x1_rr_arbiter; expectations follow MUX2X1_ARB_FIXED_PRIO_EN.
module tb_mux2x1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i0_data, i1_data, out_data;
    logic       i0_valid, i1_valid, i0_ready, i1_ready;
    logic       out_valid, out_ready, select;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] exp_d [4];
    logic       exp_s [4];
    logic [7:0] exp_after_bp;
    logic [7:0] exp_post_rst2;
    logic       exp_post_rst2_sel;
    logic [7:0] n0, n1;

    mux2x1_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i0_data   (i0_data),
        .i0_valid  (i0_valid),
        .i0_ready  (i0_ready),
        .i1_data   (i1_data),
        .i1_valid  (i1_valid),
        .i1_ready  (i1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .select    (select)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, "_data"},  {24'b0, out_data},  {24'b0, d});
        chk({tag, "_select"}, {31'b0, select},   {31'b0, s});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, "_i0_ready"}, {31'b0, i0_ready}, {31'b0, r0});
        chk({tag, "_i1_ready"}, {31'b0, i1_ready}, {31'b0, r1});
    endtask

    initial begin
`ifdef MUX2X1_ARB_FIXED_PRIO_EN
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_after_bp      = 8'h14;
        exp_post_rst2     = 8'h41;
        exp_post_rst2_sel = 1'b0;
`else
        exp_d = '{8'h10, 8'h20, 8'h11, 8'h21};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_after_bp      = 8'h12;
        exp_post_rst2     = 8'h50;
        exp_post_rst2_sel = 1'b1;
`endif

        // Reset for two cycles with both channels requesting.
        rst = 1'b1; out_ready = 1'b1;
        i0_valid = 1'b1; i1_valid = 1'b1; i0_data = 8'h01; i1_data = 8'h02;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out("reset", 1'b0, 8'h00, 1'b0);
            chk_rdy("reset", 1'b0, 1'b0);
        end

        // Single requester on channel 1.
        rst = 1'b0; i0_valid = 1'b0; i1_valid = 1'b1; i1_data = 8'hA5;
        #1;
        chk_rdy("single", 1'b0, 1'b1);
        tick();
        chk_out("single", 1'b1, 8'hA5, 1'b1);

        // Drain with nothing pending: valid drops, data/select hold.
        i1_valid = 1'b0;
        tick();
        chk_out("drain", 1'b0, 8'hA5, 1'b1);

        // Continuous contention.
        i0_valid = 1'b1; i1_valid = 1'b1; n0 = 8'h00; n1 = 8'h00;
        for (int k = 0; k < 4; k++) begin
            i0_data = 8'h10 + n0;
            i1_data = 8'h20 + n1;
            #1;
            chk_rdy("contend", !exp_s[k], exp_s[k]);
            tick();
            chk_out("contend", 1'b1, exp_d[k], exp_s[k]);
            if (exp_s[k]) n1 = n1 + 8'h01;
            else          n0 = n0 + 8'h01;
        end

        // Backpressure for three cycles, then release.
        i0_data = 8'h10 + n0;
        i1_data = 8'h20 + n1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy("bp", 1'b0, 1'b0);
            tick();
            chk_out("bp", 1'b1, exp_d[3], exp_s[3]);
        end
        out_ready = 1'b1;
        #1;
        chk_rdy("bp_release", 1'b1, 1'b0);
        tick();
        chk_out("bp_release", 1'b1, exp_after_bp, 1'b0);

        // Load 0x33, then reset while it is held.
        i0_valid = 1'b1; i1_valid = 1'b0; i0_data = 8'h33;
        tick();
        chk_out("pre_rst", 1'b1, 8'h33, 1'b0);
        out_ready = 1'b0; rst = 1'b1; i1_valid = 1'b1;
        #1;
        chk_rdy("mid_rst", 1'b0, 1'b0);
        tick();
        chk_out("mid_rst", 1'b0, 8'h00, 1'b0);

        // After reset i0 wins first contention.
        rst = 1'b0; out_ready = 1'b1; i0_data = 8'h40; i1_data = 8'h50;
        #1;
        chk_rdy("post_rst", 1'b1, 1'b0);
        tick();
        chk_out("post_rst", 1'b1, 8'h40, 1'b0);
        i0_data = 8'h41;
        tick();
        chk_out("post_rst2", 1'b1, exp_post_rst2, exp_post_rst2_sel);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
